// File: rtl/vga_seq_pkg.sv
// Shared definitions for the VGA test-pattern sequencer.
// Holds the pattern codes, the sequencer FSM encoding, the default active
// area and the pattern-advance helper.
package vga_seq_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  localparam logic [2:0] PAT_BLACK      = 3'd0;
  localparam logic [2:0] PAT_WHITE      = 3'd1;
  localparam logic [2:0] PAT_COLOR_BARS = 3'd2;
  localparam logic [2:0] PAT_GRAY_RAMP  = 3'd3;
  localparam logic [2:0] PAT_CHECKER    = 3'd4;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitFrame = 2'd1,
    StRun       = 2'd2
  } seq_state_e;

  // Advance to the next pattern, wrapping after the last one.
  function automatic logic [2:0] next_pattern(input logic [2:0] pat);
    return (pat >= PAT_CHECKER) ? PAT_BLACK : pat + 3'd1;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern generator: maps (pattern index, X, Y) to RGB.
// No active-area masking or registration here; the parent does both.
// Ports:
//   pattern            - pattern index (PAT_* code)
//   x, y               - pixel coordinate
//   red, green, blue   - 10-bit colour channels
module vga_pattern_gen
  import vga_seq_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic [2:0] pattern,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] red,
  output logic [9:0] green,
  output logic [9:0] blue
);

  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [2:0] bar;

  // Only the low three bits of the quotient are meaningful inside the active area.
  assign bar = 3'(x / BAR_W);

  always_comb begin
    red   = '0;
    green = '0;
    blue  = '0;
    case (pattern)
      PAT_WHITE: begin
        red   = 10'h3FF;
        green = 10'h3FF;
        blue  = 10'h3FF;
      end
      PAT_COLOR_BARS: begin
        red   = {10{bar[2]}};
        green = {10{bar[1]}};
        blue  = {10{bar[0]}};
      end
      PAT_GRAY_RAMP: begin
        red   = x;
        green = x;
        blue  = x;
      end
      PAT_CHECKER: begin
        red   = {10{x[5] ^ y[5]}};
        green = {10{x[5] ^ y[5]}};
        blue  = {10{x[5] ^ y[5]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// VGA test-pattern sequencer. Detects frame boundaries on the falling edge of
// iVS and cycles through five test patterns, either automatically every
// FRAMES_PER_PATTERN frames or on manual step requests. Pattern changes only
// take effect at a frame boundary so no frame mixes two patterns.
// Ports:
//   iCLK, rst                - pixel clock, async active-high reset
//   iEn, iAuto, iStep        - enable, auto-advance mode, manual step pulse
//   iVS                      - active-low vertical sync
//   iCoord_X, iCoord_Y       - current pixel coordinate
//   oRed, oGreen, oBlue      - registered pixel colour (1 cycle latency)
//   oPattern                 - pattern index matching the RGB on the outputs
//   oFrame_Tick              - one-cycle pulse per frame boundary
module vga_pattern_sequencer
  import vga_seq_pkg::*;
#(
  parameter int unsigned H_ACTIVE           = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE           = DEF_V_ACTIVE,
  parameter int unsigned FRAMES_PER_PATTERN = 60
) (
  input  logic       iCLK,
  input  logic       rst,
  input  logic       iEn,
  input  logic       iAuto,
  input  logic       iStep,
  input  logic       iVS,
  input  logic [9:0] iCoord_X,
  input  logic [9:0] iCoord_Y,
  output logic [9:0] oRed,
  output logic [9:0] oGreen,
  output logic [9:0] oBlue,
  output logic [2:0] oPattern,
  output logic       oFrame_Tick
);

  localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
  localparam logic [9:0]  CNT_LAST = 10'(FRAMES_PER_PATTERN - 1);

  seq_state_e state_q, state_d;
  logic       vs_prev_q;
  logic       tick;
  logic [2:0] idx_q, idx_d;
  logic [9:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       auto_expire;
  logic       step_req;
  logic       show;
  logic [9:0] gen_r, gen_g, gen_b;
  logic [9:0] red_d, green_d, blue_d;

  assign tick = vs_prev_q & ~iVS;

  // State register
  always_ff @(posedge iCLK or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping iEn wins from any state.
  always_comb begin
    state_d = state_q;
    if (!iEn) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:      state_d = StWaitFrame;
        StWaitFrame: if (tick) state_d = StRun;
        StRun:       state_d = StRun;
        default:     state_d = StIdle;
      endcase
    end
  end

  // Pattern / frame-counter / step-pending next values.
  assign auto_expire = iAuto && (cnt_q == CNT_LAST);
  // A step arriving in the tick cycle itself counts for that tick.
  assign step_req    = pend_q | iStep;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (!iEn || state_q == StIdle) begin
      idx_d  = PAT_BLACK;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else begin
      if (!iAuto) cnt_d = '0;
      if (iStep) pend_d = 1'b1;
      // The WAIT_FRAME->RUN tick never advances; only ticks seen in RUN do.
      if (state_q == StRun && tick) begin
        if (iAuto) cnt_d = auto_expire ? '0 : cnt_q + 10'd1;
        if (auto_expire || step_req) begin
          idx_d  = next_pattern(idx_q);
          pend_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge rst) begin
    if (rst) begin
      vs_prev_q <= 1'b1;
      idx_q     <= PAT_BLACK;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
    end else begin
      vs_prev_q <= iVS;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
    end
  end

  vga_pattern_gen #(
    .H_ACTIVE(H_ACTIVE)
  ) u_gen (
    .pattern(idx_q),
    .x      (iCoord_X),
    .y      (iCoord_Y),
    .red    (gen_r),
    .green  (gen_g),
    .blue   (gen_b)
  );

  // Output logic: blank unless running, enabled and inside the active area.
  always_comb begin
    show    = (state_q == StRun) && iEn &&
              ({1'b0, iCoord_X} < H_LIM) && ({1'b0, iCoord_Y} < V_LIM);
    red_d   = show ? gen_r : '0;
    green_d = show ? gen_g : '0;
    blue_d  = show ? gen_b : '0;
  end

  // oPattern is registered alongside RGB so the two always describe the same pixel.
  always_ff @(posedge iCLK or posedge rst) begin
    if (rst) begin
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
      oPattern    <= PAT_BLACK;
      oFrame_Tick <= 1'b0;
    end else begin
      oRed        <= red_d;
      oGreen      <= green_d;
      oBlue       <= blue_d;
      oPattern    <= idx_q;
      oFrame_Tick <= tick;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed, table-driven bench for vga_pattern_sequencer (FRAMES_PER_PATTERN = 3).
module tb_vga_pattern_sequencer;

  logic       iCLK = 1'b0;
  logic       rst = 1'b0;
  logic       iEn = 1'b0;
  logic       iAuto = 1'b0;
  logic       iStep = 1'b0;
  logic       iVS = 1'b1;
  logic [9:0] iCoord_X = '0;
  logic [9:0] iCoord_Y = '0;
  logic [9:0] oRed, oGreen, oBlue;
  logic [2:0] oPattern;
  logic       oFrame_Tick;

  int n_cmp = 0;
  int n_err = 0;

  vga_pattern_sequencer #(
    .H_ACTIVE          (640),
    .V_ACTIVE          (480),
    .FRAMES_PER_PATTERN(3)
  ) dut (
    .iCLK       (iCLK),
    .rst        (rst),
    .iEn        (iEn),
    .iAuto      (iAuto),
    .iStep      (iStep),
    .iVS        (iVS),
    .iCoord_X   (iCoord_X),
    .iCoord_Y   (iCoord_Y),
    .oRed       (oRed),
    .oGreen     (oGreen),
    .oBlue      (oBlue),
    .oPattern   (oPattern),
    .oFrame_Tick(oFrame_Tick)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [2:0] pat;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } vec_t;

  vec_t vec [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rgb_now();
    return {2'b00, oRed, oGreen, oBlue};
  endfunction

  function automatic logic [31:0] rgb_of(input logic [9:0] r, input logic [9:0] g,
                                         input logic [9:0] b);
    return {2'b00, r, g, b};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  // One iVS falling edge; on return oPattern reflects any advance at that tick.
  task automatic frame_tick();
    iVS = 1'b0;
    cyc();
    iVS = 1'b1;
    cyc();
  endtask

  task automatic step_pulse();
    iStep = 1'b1;
    cyc();
    iStep = 1'b0;
    cyc();
  endtask

  logic [2:0] exp_pat;
  int         exp_cnt;

  initial begin
    vec[0]  = '{3'd2, 10'd85,  10'd10,  10'h000, 10'h000, 10'h3FF};
    vec[1]  = '{3'd2, 10'd640, 10'd10,  10'h000, 10'h000, 10'h000};
    vec[2]  = '{3'd2, 10'd0,   10'd0,   10'h000, 10'h000, 10'h000};
    vec[3]  = '{3'd2, 10'd639, 10'd479, 10'h3FF, 10'h3FF, 10'h3FF};
    vec[4]  = '{3'd2, 10'd250, 10'd5,   10'h000, 10'h3FF, 10'h3FF};
    vec[5]  = '{3'd2, 10'd100, 10'd480, 10'h000, 10'h000, 10'h000};
    vec[6]  = '{3'd3, 10'd300, 10'd0,   10'd300, 10'd300, 10'd300};
    vec[7]  = '{3'd3, 10'd639, 10'd100, 10'd639, 10'd639, 10'd639};
    vec[8]  = '{3'd4, 10'd32,  10'd0,   10'h3FF, 10'h3FF, 10'h3FF};
    vec[9]  = '{3'd4, 10'd32,  10'd32,  10'h000, 10'h000, 10'h000};
    vec[10] = '{3'd4, 10'd0,   10'd40,  10'h3FF, 10'h3FF, 10'h3FF};
    vec[11] = '{3'd4, 10'd10,  10'd10,  10'h000, 10'h000, 10'h000};
    vec[12] = '{3'd0, 10'd100, 10'd10,  10'h000, 10'h000, 10'h000};
    vec[13] = '{3'd1, 10'd100, 10'd100, 10'h3FF, 10'h3FF, 10'h3FF};
    vec[14] = '{3'd1, 10'd700, 10'd100, 10'h000, 10'h000, 10'h000};

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("reset rgb", rgb_now(), 32'h0);
    check("reset pattern", {29'b0, oPattern}, 32'h0);
    check("reset frame_tick", {31'b0, oFrame_Tick}, 32'h0);
    cyc(2);
    rst = 1'b0;
    cyc();

    // Enable mid-frame: blank until the first iVS fall, then pattern 0.
    iEn = 1'b1;
    iCoord_X = 10'd100;
    iCoord_Y = 10'd10;
    cyc(3);
    check("wait rgb", rgb_now(), 32'h0);
    check("wait pattern", {29'b0, oPattern}, 32'h0);
    iVS = 1'b0;
    cyc();
    check("first tick pulse", {31'b0, oFrame_Tick}, 32'h1);
    iVS = 1'b1;
    cyc();
    check("first tick pulse end", {31'b0, oFrame_Tick}, 32'h0);
    check("first frame pattern", {29'b0, oPattern}, 32'h0);

    // Manual steps: three pulses in one frame collapse to one advance.
    step_pulse();
    step_pulse();
    step_pulse();
    check("no mid-frame advance", {29'b0, oPattern}, 32'h0);
    frame_tick();
    check("step collapse", {29'b0, oPattern}, 32'h1);
    cyc();
    check("white rgb", rgb_now(), rgb_of(10'h3FF, 10'h3FF, 10'h3FF));
    frame_tick();
    check("pending cleared", {29'b0, oPattern}, 32'h1);
    // Step coincident with the tick is consumed at that tick.
    iVS = 1'b0;
    iStep = 1'b1;
    cyc();
    iStep = 1'b0;
    iVS = 1'b1;
    cyc();
    check("step at tick", {29'b0, oPattern}, 32'h2);

    // Table of pattern/coordinate vectors; advance by manual steps as needed.
    exp_pat = 3'd2;
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 5 && exp_pat != vec[i].pat; k++) begin
        step_pulse();
        frame_tick();
        exp_pat = (exp_pat == 3'd4) ? 3'd0 : exp_pat + 3'd1;
      end
      iCoord_X = vec[i].x;
      iCoord_Y = vec[i].y;
      cyc();
      check($sformatf("vec%0d pattern", i), {29'b0, oPattern}, {29'b0, vec[i].pat});
      check($sformatf("vec%0d rgb", i), rgb_now(), rgb_of(vec[i].r, vec[i].g, vec[i].b));
    end

    // Auto mode from pattern 1 with counter at 0.
    iAuto = 1'b1;
    exp_pat = 3'd1;
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      frame_tick();
      if (exp_cnt == 2) begin
        exp_cnt = 0;
        exp_pat = (exp_pat == 3'd4) ? 3'd0 : exp_pat + 3'd1;
      end else begin
        exp_cnt++;
      end
      check($sformatf("auto tick%0d", i), {29'b0, oPattern}, {29'b0, exp_pat});
    end

    // Auto expiry coinciding with a pending step: one advance, both cleared.
    frame_tick();
    frame_tick();
    check("auto pre-expiry", {29'b0, oPattern}, 32'h0);
    step_pulse();
    frame_tick();
    check("coincide advance", {29'b0, oPattern}, 32'h1);
    frame_tick();
    frame_tick();
    check("coincide cleared", {29'b0, oPattern}, 32'h1);
    iVS = 1'b0;
    cyc();
    check("pattern lags tick", {29'b0, oPattern}, 32'h1);
    iVS = 1'b1;
    cyc();
    check("auto after coincide", {29'b0, oPattern}, 32'h2);

    // Reset mid-RUN with a step pending.
    iAuto = 1'b0;
    iCoord_X = 10'd85;
    iCoord_Y = 10'd10;
    cyc();
    check("bars before reset", rgb_now(), rgb_of(10'h000, 10'h000, 10'h3FF));
    iStep = 1'b1;
    cyc();
    iStep = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async reset rgb", rgb_now(), 32'h0);
    check("async reset pattern", {29'b0, oPattern}, 32'h0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("post-reset wait pattern", {29'b0, oPattern}, 32'h0);
    frame_tick();
    check("post-reset entry", {29'b0, oPattern}, 32'h0);
    frame_tick();
    check("step dropped by reset", {29'b0, oPattern}, 32'h0);
    step_pulse();
    frame_tick();
    check("post-reset step", {29'b0, oPattern}, 32'h1);
    check("post-reset white", rgb_now(), rgb_of(10'h3FF, 10'h3FF, 10'h3FF));

    // Disable: blank on the next cycle, index back to 0.
    iEn = 1'b0;
    cyc();
    check("disable rgb", rgb_now(), 32'h0);
    cyc();
    check("disable pattern", {29'b0, oPattern}, 32'h0);
    iEn = 1'b1;
    iStep = 1'b0;
    cyc(2);
    check("re-enable wait rgb", rgb_now(), 32'h0);
    frame_tick();
    check("re-enable entry", {29'b0, oPattern}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
